// File: rtl/lavagem_pkg.sv
// Shared definitions for the washing-machine controller.
//   estado_t    : state encoding, also driven on the estado output
//   *_PAD       : default phase durations and counter width
package lavagem_pkg;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        ENCHER    = 3'd1,
        LAVAR     = 3'd2,
        ESVAZIAR  = 3'd3,
        ENXAGUAR  = 3'd4,
        SECAGEM   = 3'd5,
        CONCLUIDO = 3'd6,
        ERRO      = 3'd7
    } estado_t;

    localparam int T_LAVAR_PAD     = 8;
    localparam int T_ENXAGUE_PAD   = 6;
    localparam int T_SECAR_PAD     = 10;
    localparam int T_MAX_NIVEL_PAD = 20;
    localparam int CONT_W_PAD      = 8;

endpackage

// File: rtl/temporizador_fase.sv
// Phase counter with clear, enable and terminal-count compare.
//   clock, reset : system clock, synchronous active-high reset
//   limpar       : clear to 0 (asserted on the cycle a state is left)
//   habilitar    : count this cycle
//   limite       : terminal value; the counter saturates there
//   terminal     : count equals limite
module temporizador_fase
    import lavagem_pkg::*;
#(
    parameter int CONT_W = CONT_W_PAD
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              limpar,
    input  logic              habilitar,
    input  logic [CONT_W-1:0] limite,
    output logic              terminal
);

    logic [CONT_W-1:0] contagem;

    always_ff @(posedge clock) begin
        if (reset || limpar) begin
            contagem <= '0;
        end else if (habilitar && (contagem != limite)) begin
            // Stops at the limit instead of wrapping around.
            contagem <= contagem + 1'b1;
        end
    end

    assign terminal = (contagem == limite);

endmodule

// File: rtl/controle_lavagem.sv
// Washing-machine sequence controller.
//   clock, reset  : system clock, synchronous active-high reset
//   inicio        : start request (only honoured in OCIOSO)
//   cheio, vazio  : tank full / tank empty sensors
//   secar         : spin-dry option, latched when a cycle starts
//   pausa         : freezes the sequence and switches actuators off
//   valvula, motor, bomba, secador : actuators
//   fim           : one-cycle completion pulse
//   erro          : fill/drain timeout, held until reset
//   estado        : current state code
module controle_lavagem
    import lavagem_pkg::*;
#(
    parameter int T_LAVAR     = T_LAVAR_PAD,
    parameter int T_ENXAGUE   = T_ENXAGUE_PAD,
    parameter int T_SECAR     = T_SECAR_PAD,
    parameter int T_MAX_NIVEL = T_MAX_NIVEL_PAD,
    parameter int CONT_W      = CONT_W_PAD
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       inicio,
    input  logic       cheio,
    input  logic       vazio,
    input  logic       secar,
    input  logic       pausa,
    output logic       valvula,
    output logic       motor,
    output logic       bomba,
    output logic       secador,
    output logic       fim,
    output logic       erro,
    output logic [2:0] estado
);

    estado_t           st;
    logic              secar_r;
    logic              enx_r;
    logic              sai;
    logic              terminal;
    logic [CONT_W-1:0] limite;

    // Terminal value of the phase counter for the current state.
    always_comb begin
        limite = '0;
        case (st)
            ENCHER, ESVAZIAR: limite = CONT_W'(T_MAX_NIVEL - 1);
            LAVAR:            limite = CONT_W'(T_LAVAR - 1);
            ENXAGUAR:         limite = CONT_W'(T_ENXAGUE - 1);
            SECAGEM:          limite = CONT_W'(T_SECAR - 1);
            default:          limite = '0;
        endcase
    end

    // State is left this cycle; used to clear the counter so every
    // state starts counting from 0.
    always_comb begin
        sai = 1'b0;
        case (st)
            OCIOSO:                   sai = inicio;
            ENCHER:                   sai = !pausa && (cheio || terminal);
            ESVAZIAR:                 sai = !pausa && (vazio || terminal);
            LAVAR, ENXAGUAR, SECAGEM: sai = !pausa && terminal;
            CONCLUIDO:                sai = 1'b1;
            default:                  sai = 1'b0;
        endcase
    end

    temporizador_fase #(
        .CONT_W (CONT_W)
    ) u_temporizador (
        .clock     (clock),
        .reset     (reset),
        .limpar    (sai),
        .habilitar (!pausa),
        .limite    (limite),
        .terminal  (terminal)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            st      <= OCIOSO;
            secar_r <= 1'b0;
            enx_r   <= 1'b0;
        end else begin
            case (st)
                OCIOSO: begin
                    if (inicio) begin
                        st      <= ENCHER;
                        secar_r <= secar;
                        enx_r   <= 1'b0;
                    end
                end
                ENCHER: begin
                    // Sensor is checked first so it wins over the timeout.
                    if (!pausa) begin
                        if (cheio)         st <= enx_r ? ENXAGUAR : LAVAR;
                        else if (terminal) st <= ERRO;
                    end
                end
                LAVAR: begin
                    if (!pausa && terminal) st <= ESVAZIAR;
                end
                ESVAZIAR: begin
                    if (!pausa) begin
                        if (vazio) begin
                            if (!enx_r) begin
                                enx_r <= 1'b1;
                                st    <= ENCHER;
                            end else begin
                                st <= secar_r ? SECAGEM : CONCLUIDO;
                            end
                        end else if (terminal) begin
                            st <= ERRO;
                        end
                    end
                end
                ENXAGUAR: begin
                    if (!pausa && terminal) st <= ESVAZIAR;
                end
                SECAGEM: begin
                    if (!pausa && terminal) st <= CONCLUIDO;
                end
                CONCLUIDO: st <= OCIOSO;
                ERRO:      st <= ERRO;
                default:   st <= ERRO;
            endcase
        end
    end

    // Moore decode of the registered state; pausa only gates actuators.
    always_comb begin
        valvula = 1'b0;
        motor   = 1'b0;
        bomba   = 1'b0;
        secador = 1'b0;
        fim     = 1'b0;
        erro    = 1'b0;
        case (st)
            ENCHER:          valvula = !pausa;
            LAVAR, ENXAGUAR: motor   = !pausa;
            ESVAZIAR:        bomba   = !pausa;
            SECAGEM: begin
                motor   = !pausa;
                secador = !pausa;
                bomba   = !pausa;
            end
            CONCLUIDO:       fim  = 1'b1;
            ERRO:            erro = 1'b1;
            default: ;
        endcase
    end

    assign estado = st;

endmodule

// File: tb/tb_controle_lavagem.sv
module tb_controle_lavagem;

    localparam logic [2:0] S_OCIOSO    = 3'd0;
    localparam logic [2:0] S_ENCHER    = 3'd1;
    localparam logic [2:0] S_LAVAR     = 3'd2;
    localparam logic [2:0] S_ESVAZIAR  = 3'd3;
    localparam logic [2:0] S_ENXAGUAR  = 3'd4;
    localparam logic [2:0] S_SECAGEM   = 3'd5;
    localparam logic [2:0] S_CONCLUIDO = 3'd6;
    localparam logic [2:0] S_ERRO      = 3'd7;

    typedef struct packed {
        logic [2:0] est;
        logic       valvula;
        logic       motor;
        logic       bomba;
        logic       secador;
        logic       fim;
        logic       erro;
    } obs_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic inicio = 1'b0;
    logic cheio = 1'b0;
    logic vazio = 1'b0;
    logic secar = 1'b0;
    logic pausa = 1'b0;
    logic valvula, motor, bomba, secador, fim, erro;
    logic [2:0] estado;

    int testes = 0;
    int falhas = 0;
    string cenario = "";
    obs_t fila[$];

    always #5 clock = ~clock;

    controle_lavagem dut (
        .clock   (clock),
        .reset   (reset),
        .inicio  (inicio),
        .cheio   (cheio),
        .vazio   (vazio),
        .secar   (secar),
        .pausa   (pausa),
        .valvula (valvula),
        .motor   (motor),
        .bomba   (bomba),
        .secador (secador),
        .fim     (fim),
        .erro    (erro),
        .estado  (estado)
    );

    // Expected outputs for a state, straight from the output table.
    function automatic obs_t esperado(logic [2:0] st, logic p);
        obs_t o;
        o = '0;
        o.est = st;
        case (st)
            S_ENCHER:              o.valvula = !p;
            S_LAVAR, S_ENXAGUAR:   o.motor = !p;
            S_ESVAZIAR:            o.bomba = !p;
            S_SECAGEM: begin
                o.motor = !p; o.secador = !p; o.bomba = !p;
            end
            S_CONCLUIDO:           o.fim = 1'b1;
            S_ERRO:                o.erro = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    // One clock: expected state after the edge is queued, then compared.
    // pausa may be changed right after the edge (p_depois).
    task automatic ciclo_p(input logic [2:0] st, input logic p_depois);
        obs_t exp_o, obs_o;
        fila.push_back(esperado(st, p_depois));
        @(posedge clock);
        #1;
        pausa = p_depois;
        #1;
        exp_o = fila.pop_front();
        obs_o = {estado, valvula, motor, bomba, secador, fim, erro};
        testes++;
        if (obs_o !== exp_o) begin
            falhas++;
            $display("FAIL %s t=%0t: got estado=%0d vmbsfe=%b, expected estado=%0d vmbsfe=%b",
                     cenario, $time, obs_o.est, obs_o[5:0], exp_o.est, exp_o[5:0]);
        end
    endtask

    task automatic ciclo(input logic [2:0] st);
        ciclo_p(st, pausa);
    endtask

    // Comparison within the current cycle, without a clock edge.
    task automatic agora(input logic [2:0] st);
        obs_t exp_o, obs_o;
        fila.push_back(esperado(st, pausa));
        #1;
        exp_o = fila.pop_front();
        obs_o = {estado, valvula, motor, bomba, secador, fim, erro};
        testes++;
        if (obs_o !== exp_o) begin
            falhas++;
            $display("FAIL %s t=%0t (now): got estado=%0d vmbsfe=%b, expected estado=%0d vmbsfe=%b",
                     cenario, $time, obs_o.est, obs_o[5:0], exp_o.est, exp_o[5:0]);
        end
    endtask

    // Called while observing the first ENCHER cycle; cheio rises after espera cycles.
    task automatic encher(input logic [2:0] prox, input int espera);
        repeat (espera) ciclo(S_ENCHER);
        cheio = 1'b1;
        ciclo(prox);
        cheio = 1'b0;
    endtask

    task automatic esvaziar(input logic [2:0] prox, input int espera);
        repeat (espera) ciclo(S_ESVAZIAR);
        vazio = 1'b1;
        ciclo(prox);
        vazio = 1'b0;
    endtask

    // Called while observing the first cycle of a timed phase.
    task automatic fase(input logic [2:0] st, input int dur, input logic [2:0] prox);
        repeat (dur - 1) ciclo(st);
        ciclo(prox);
    endtask

    task automatic aplicar_reset();
        reset = 1'b1;
        ciclo(S_OCIOSO);
        reset = 1'b0;
    endtask

    task automatic iniciar(input logic opcao_secar);
        inicio = 1'b1;
        secar = opcao_secar;
        ciclo(S_ENCHER);
        inicio = 1'b0;
        secar = 1'b0;
    endtask

    task automatic test_reset();
        cenario = "reset";
        reset = 1'b1;
        inicio = 1'b1;
        @(posedge clock);
        ciclo(S_OCIOSO);
        ciclo(S_OCIOSO);
        reset = 1'b0;
        inicio = 1'b0;
        ciclo(S_OCIOSO);
    endtask

    task automatic test_ciclo_completo();
        cenario = "ciclo_completo";
        iniciar(1'b1);
        encher(S_LAVAR, 3);
        fase(S_LAVAR, 8, S_ESVAZIAR);
        esvaziar(S_ENCHER, 2);
        inicio = 1'b1;              // ignored outside OCIOSO
        encher(S_ENXAGUAR, 3);
        inicio = 1'b0;
        fase(S_ENXAGUAR, 6, S_ESVAZIAR);
        esvaziar(S_SECAGEM, 2);
        fase(S_SECAGEM, 10, S_CONCLUIDO);
        ciclo(S_OCIOSO);
        ciclo(S_OCIOSO);
    endtask

    task automatic test_sem_secagem();
        cenario = "sem_secagem";
        iniciar(1'b0);
        secar = 1'b1;               // too late, must be ignored
        encher(S_LAVAR, 1);
        fase(S_LAVAR, 8, S_ESVAZIAR);
        esvaziar(S_ENCHER, 0);
        encher(S_ENXAGUAR, 0);
        fase(S_ENXAGUAR, 6, S_ESVAZIAR);
        esvaziar(S_CONCLUIDO, 1);
        ciclo(S_OCIOSO);
        secar = 1'b0;
    endtask

    task automatic test_timeout();
        cenario = "timeout";
        iniciar(1'b0);
        repeat (19) ciclo(S_ENCHER);
        ciclo(S_ERRO);              // 20 cycles after ENCHER entry
        inicio = 1'b1;
        ciclo(S_ERRO);
        ciclo(S_ERRO);
        inicio = 1'b0;
        pausa = 1'b1;
        agora(S_ERRO);
        ciclo_p(S_ERRO, 1'b0);
        aplicar_reset();
    endtask

    task automatic test_sensor_vence_timeout();
        cenario = "sensor_vs_timeout";
        iniciar(1'b0);
        encher(S_LAVAR, 19);
        aplicar_reset();
    endtask

    task automatic test_pausa();
        cenario = "pausa";
        iniciar(1'b0);
        encher(S_LAVAR, 0);
        repeat (3) ciclo(S_LAVAR);  // now at count 3
        pausa = 1'b1;
        agora(S_LAVAR);
        repeat (4) ciclo(S_LAVAR);
        ciclo_p(S_LAVAR, 1'b0);     // resumes at count 3
        repeat (4) ciclo(S_LAVAR);
        ciclo(S_ESVAZIAR);
        // Sensor change is ignored while paused.
        vazio = 1'b1;
        pausa = 1'b1;
        agora(S_ESVAZIAR);
        ciclo_p(S_ESVAZIAR, 1'b0);
        ciclo(S_ENCHER);
        vazio = 1'b0;
        aplicar_reset();
    endtask

    task automatic test_reset_secagem();
        cenario = "reset_secagem";
        iniciar(1'b1);
        encher(S_LAVAR, 0);
        fase(S_LAVAR, 8, S_ESVAZIAR);
        esvaziar(S_ENCHER, 0);
        encher(S_ENXAGUAR, 0);
        fase(S_ENXAGUAR, 6, S_ESVAZIAR);
        esvaziar(S_SECAGEM, 0);
        repeat (4) ciclo(S_SECAGEM);
        aplicar_reset();
        ciclo(S_OCIOSO);
        iniciar(1'b0);
        ciclo(S_ENCHER);
        aplicar_reset();
    endtask

    task automatic test_back_to_back();
        cenario = "back_to_back";
        iniciar(1'b0);
        encher(S_LAVAR, 0);
        fase(S_LAVAR, 8, S_ESVAZIAR);
        esvaziar(S_ENCHER, 0);
        encher(S_ENXAGUAR, 0);
        fase(S_ENXAGUAR, 6, S_ESVAZIAR);
        inicio = 1'b1;              // held through CONCLUIDO into OCIOSO
        esvaziar(S_CONCLUIDO, 0);
        ciclo(S_OCIOSO);
        ciclo(S_ENCHER);
        inicio = 1'b0;
        aplicar_reset();
    endtask

    initial begin
        test_reset();
        test_ciclo_completo();
        test_sem_secagem();
        test_timeout();
        test_sensor_vence_timeout();
        test_pausa();
        test_reset_secagem();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule
